// File: rtl/uart_tx.sv
// uart_tx: RS-232 serial transmitter.
// Frames one byte per accepted request as start / 8 data bits LSB-first /
// optional parity / 1 or 2 stop bits, each bit lasting BAUD_DIV clocks.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_snd_start  send request, honoured only while idle
//   i_snd_data   byte to send, captured on the accepting edge
//   o_txd        registered serial line, idle high
//   o_snd_busy   registered, high while a frame is in progress
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned PARITY    = 0,  // 0 none, 1 odd, 2 even
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_snd_start,
  input  logic [7:0] i_snd_data,
  output logic       o_txd,
  output logic       o_snd_busy
);

  localparam int unsigned BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx: BAUD_DIV must be at least 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_par, w_par_nxt;  // XOR of the accepted byte
  logic             r_txd, w_txd_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_bit_end;

  assign w_bit_end = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_txd_nxt      = r_txd;
    w_busy_nxt     = r_busy;

    unique case (r_state)
      StIdle: begin
        w_baud_cnt_nxt = '0;
        w_bit_cnt_nxt  = '0;
        w_txd_nxt      = 1'b1;
        w_busy_nxt     = 1'b0;
        if (i_snd_start) begin
          w_state_nxt = StStart;
          w_shift_nxt = i_snd_data;
          w_par_nxt   = ^i_snd_data;
          w_txd_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_nxt   = StData;
          w_txd_nxt     = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = '0;
        end
      end
      StData: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt = '0;
            if (PARITY != 0) begin
              w_state_nxt = StParity;
              // Odd mode inverts the data XOR so the total ones count is odd.
              w_txd_nxt   = (PARITY == 1) ? ~r_par : r_par;
            end else begin
              w_state_nxt = StStop;
              w_txd_nxt   = 1'b1;
            end
          end else begin
            w_txd_nxt     = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      StParity: begin
        if (w_bit_end) begin
          w_state_nxt   = StStop;
          w_txd_nxt     = 1'b1;
          w_bit_cnt_nxt = '0;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'(STOP_BITS - 1)) begin
            w_state_nxt   = StIdle;
            w_busy_nxt    = 1'b0;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign o_txd      = r_txd;
  assign o_snd_busy = r_busy;

endmodule
